// File: rtl/sqrt_task_distributor_if.sv
// Bundle of every handshake and worker-side signal of the square-root task
// distributor.
//   slave  : distributor view (accepts triples, drives workers, returns results)
//   master : environment view (issues triples, plays the workers, takes results)
// Signals:
//   arg_vld/arg_rdy, a/b/c        argument triple handshake
//   res_vld/res_rdy, res          in-order result handshake
//   wrk_arg_vld, wrk_a/b/c        per-worker start pulse and operands (slice i -> worker i)
//   wrk_res_vld, wrk_res          per-worker completion pulse and result
//   busy_cnt                      number of slots not idle
interface sqrt_task_distributor_if #(
    parameter int N_WORKERS = 4,
    parameter int WIDTH     = 32
);
    localparam int CW = $clog2(N_WORKERS + 1);

    logic                       arg_vld;
    logic                       arg_rdy;
    logic [WIDTH-1:0]           a;
    logic [WIDTH-1:0]           b;
    logic [WIDTH-1:0]           c;
    logic                       res_vld;
    logic                       res_rdy;
    logic [WIDTH-1:0]           res;
    logic [N_WORKERS-1:0]       wrk_arg_vld;
    logic [N_WORKERS*WIDTH-1:0] wrk_a;
    logic [N_WORKERS*WIDTH-1:0] wrk_b;
    logic [N_WORKERS*WIDTH-1:0] wrk_c;
    logic [N_WORKERS-1:0]       wrk_res_vld;
    logic [N_WORKERS*WIDTH-1:0] wrk_res;
    logic [CW-1:0]              busy_cnt;

    modport slave (
        input  arg_vld, a, b, c, res_rdy, wrk_res_vld, wrk_res,
        output arg_rdy, res_vld, res, wrk_arg_vld, wrk_a, wrk_b, wrk_c, busy_cnt
    );

    modport master (
        output arg_vld, a, b, c, res_rdy, wrk_res_vld, wrk_res,
        input  arg_rdy, res_vld, res, wrk_arg_vld, wrk_a, wrk_b, wrk_c, busy_cnt
    );
endinterface

// File: rtl/sqrt_task_distributor.sv
// Square-root task distributor: hands argument triples to a ring of worker
// slots and returns the workers' results strictly in acceptance order.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - sqrt_task_distributor_if.slave (argument, result and worker signals)
// Each slot is IDLE -> BUSY (accepted) -> DONE (worker finished) -> IDLE
// (result taken). wr_ptr allocates slots, rd_ptr retires them; because
// retirement is in order, occupied slots always form a contiguous run
// rd_ptr..wr_ptr-1, which is what keeps the output in acceptance order.
module sqrt_task_distributor #(
    parameter int N_WORKERS = 4,
    parameter int WIDTH     = 32
) (
    input logic                   clk,
    input logic                   rst,
    sqrt_task_distributor_if.slave bus
);
    localparam int PW = $clog2(N_WORKERS);
    localparam int CW = $clog2(N_WORKERS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} slot_state_t;

    slot_state_t                     state     [N_WORKERS];
    slot_state_t                     state_nxt [N_WORKERS];
    logic [PW-1:0]                   wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]                   rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]                   cnt, cnt_nxt;
    logic [N_WORKERS-1:0]            start_q, start_nxt;
    logic [N_WORKERS-1:0][WIDTH-1:0] op_a, op_b, op_c, res_q;
    logic [N_WORKERS-1:0][WIDTH-1:0] wrk_res_s;

    logic arg_rdy, res_vld, accept, rel;

    // Ready/valid depend on registered slot state only, so a slot freed this
    // cycle cannot show up on arg_rdy until the next one.
    assign arg_rdy   = (state[wr_ptr] == IDLE);
    assign res_vld   = (state[rd_ptr] == DONE);
    assign accept    = bus.arg_vld && arg_rdy;
    assign rel       = res_vld && bus.res_rdy;
    assign wrk_res_s = bus.wrk_res;

    assign bus.arg_rdy     = arg_rdy;
    assign bus.res_vld     = res_vld;
    assign bus.res         = res_q[rd_ptr];
    assign bus.wrk_arg_vld = start_q;
    assign bus.wrk_a       = op_a;
    assign bus.wrk_b       = op_b;
    assign bus.wrk_c       = op_c;
    assign bus.busy_cnt    = cnt;

    // Next state. Accept only hits an IDLE slot, completion only a BUSY one and
    // release only a DONE one, so the three updates never collide on a slot.
    always_comb begin
        state_nxt  = state;
        start_nxt  = '0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        for (int i = 0; i < N_WORKERS; i++) begin
            if (state[i] == BUSY && bus.wrk_res_vld[i]) state_nxt[i] = DONE;
        end
        if (accept) begin
            state_nxt[wr_ptr] = BUSY;
            start_nxt[wr_ptr] = 1'b1;
            wr_ptr_nxt = (wr_ptr == PW'(N_WORKERS - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (rel) begin
            state_nxt[rd_ptr] = IDLE;
            rd_ptr_nxt = (rd_ptr == PW'(N_WORKERS - 1)) ? '0 : rd_ptr + 1'b1;
        end
        if (accept && !rel)      cnt_nxt = cnt + 1'b1;
        else if (!accept && rel) cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WORKERS; i++) state[i] <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            start_q <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_c    <= '0;
            res_q   <= '0;
        end else begin
            for (int i = 0; i < N_WORKERS; i++) begin
                state[i] <= state_nxt[i];
                // Operands stay put until the slot is reallocated, which keeps
                // them stable for the whole BUSY period.
                if (accept && wr_ptr == PW'(i)) begin
                    op_a[i] <= bus.a;
                    op_b[i] <= bus.b;
                    op_c[i] <= bus.c;
                end
                if (state[i] == BUSY && bus.wrk_res_vld[i]) res_q[i] <= wrk_res_s[i];
            end
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            cnt     <= cnt_nxt;
            start_q <= start_nxt;
        end
    end
endmodule
